shift_rx: RTL and testbench
===========================

Name: shift_rx

Overview:
Serial-to-parallel receiver for the three-wire sclk/data/latch display-chain interface. It oversamples externally driven sclk, data and latch lines on the system clock. Incoming bits are shifted MSB-first; a full word is presented on a latch pulse. It acts as the receiving end of the shift-register driver, for loopback verification and for reading chained input shift registers.

Parameters:
WIDTH, 48, number of bits per frame (>= 2)
TIMEOUT_CYCLES, 1024, idle clk cycles before a partial frame is discarded (used only with SHIFT_RX_TIMEOUT_EN)

Ports:
clk_i  input  1  system clock; the only clock
rst_i  input  1  reset, asynchronous, active-high
sclk_i  input  1  serial clock, asynchronous to clk_i; bit sampled on rising edge
data_i  input  1  serial data, asynchronous
latch_i  input  1  frame latch, asynchronous; rising edge ends frame
data_o  output  WIDTH  last valid received word
valid_o  output  1  one-cycle pulse when data_o updates
err_o  output  1  one-cycle pulse on a bad frame (wrong bit count or timeout)
busy_o  output  1  high while bit_cnt != 0

Behaviour:
- Reset (async, rst_i high): data_o=0, valid_o=0, err_o=0, busy_o=0, shift register=0, bit_cnt=0, all synchroniser flops=0.
- Each input passes through 2 sync flops (s1, s2) plus a history flop (s3). Rising edge detect = s2 & ~s3. Action happens on the clk edge where the detect is true, so an input rise reaches outputs on the 3rd clk edge after it becomes stable.
- Input timing contract: sclk_i and latch_i high/low phases are >= 2 clk cycles each. data_i is stable from 1 clk cycle before until 2 cycles after each sclk_i rise.
- Shift: on sclk rise, shreg <= {shreg[WIDTH-2:0], data_s2}. bit_cnt increments, saturating at WIDTH+1.
- State is derived from bit_cnt:
  - IDLE: cnt=0.
  - SHIFT: 0<cnt<WIDTH.
  - FULL: cnt=WIDTH.
  - OVER: cnt=WIDTH+1, meaning too many bits. Later bits still shift in; the count stays at WIDTH+1.
- Latch rise:
  - In FULL: data_o <= shreg, valid_o=1 for one cycle.
  - In any other state: data_o unchanged, err_o=1 for one cycle.
  - In all cases: bit_cnt <= 0 and shreg is kept.
- Simultaneous sclk rise and latch rise in the same cycle: the shift is applied first. The latch then evaluates the post-shift count and value, so the new bit is included.
- First bit received lands in data_o[WIDTH-1]; last bit lands in data_o[0].
- busy_o = (bit_cnt != 0), registered together with bit_cnt.
- valid_o and err_o never assert in the same cycle. Neither is ever high for more than one cycle per latch.
- Reset mid-frame: all state cleared immediately; no pulse is generated.

Optional Feature:
Macro SHIFT_RX_TIMEOUT_EN.
- Defined: an idle counter clears on every sclk or latch rise and increments while bit_cnt != 0. When it reaches TIMEOUT_CYCLES, bit_cnt <= 0, err_o pulses once, and the counter clears. The counter is inactive in IDLE.
- Undefined: no counter is built; a partial frame is held indefinitely until latch or reset; TIMEOUT_CYCLES is ignored.

Test Plan:
- Nominal frame: shift 48'hA5A5_0123_FEDC MSB-first with 4-cycle sclk phases, then latch -> data_o=48'hA5A5_0123_FEDC and valid_o high exactly 1 cycle, 3 clk edges after latch_i rises; err_o=0; busy_o=0 afterwards.
- Short frame: 47 bits then latch -> err_o 1-cycle pulse, valid_o=0, data_o keeps the previous word, bit_cnt=0. Next full 48-bit frame of 48'h0000_0000_0001 -> valid_o and data_o=48'h1.
- Long frame: 50 bits then latch -> err_o pulse, data_o unchanged. A following correct 48-bit frame is accepted.
- Coincident edge: 47 bits, then the 48th sclk rise and the latch rise driven in the same clk cycle with last bit=1 -> valid_o pulse, data_o[0]=1.
- Reset mid-frame: assert rst_i after 20 bits -> all outputs 0 asynchronously. Then a full 48'hFFFF_FFFF_FFFF frame -> data_o=48'hFFFF_FFFF_FFFF.
- Timeout (SHIFT_RX_TIMEOUT_EN defined, TIMEOUT_CYCLES=16): 10 bits then idle for 16 cycles -> single err_o pulse, busy_o falls. A subsequent full frame is received correctly. With the macro undefined, the same stimulus gives no err_o and busy_o stays 1.

Source files
------------

// File: rtl/shift_rx.sv
//============================================================================
// Module      : shift_rx
// Description : Serial-to-parallel receiver for a sclk/data/latch chain.
//               Optional idle timeout enabled by SHIFT_RX_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module shift_rx #(
    parameter int WIDTH          = 48,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sclk_i,
    input  logic             data_i,
    input  logic             latch_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             err_o,
    output logic             busy_o
);

    localparam int C_CNT_W = $clog2(WIDTH + 2);
    localparam logic [C_CNT_W-1:0] C_FULL = C_CNT_W'(WIDTH);
    localparam logic [C_CNT_W-1:0] C_OVER = C_CNT_W'(WIDTH + 1);

    logic [2:0]         r_sclk_sync;
    logic [2:0]         r_latch_sync;
    logic [1:0]         r_data_sync;
    logic [WIDTH-1:0]   r_shreg;
    logic [C_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_data;
    logic               r_valid;
    logic               r_err;
    logic               r_busy;

    logic               w_sclk_rise;
    logic               w_latch_rise;
    logic               w_timeout;
    logic [WIDTH-1:0]   w_shreg_next;
    logic [C_CNT_W-1:0] w_cnt_next;
    logic               w_valid_next;
    logic               w_err_next;
    logic               w_load;

    assign w_sclk_rise  = r_sclk_sync[1]  & ~r_sclk_sync[2];
    assign w_latch_rise = r_latch_sync[1] & ~r_latch_sync[2];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sclk_sync  <= '0;
            r_latch_sync <= '0;
            r_data_sync  <= '0;
        end else begin
            r_sclk_sync  <= {r_sclk_sync[1:0], sclk_i};
            r_latch_sync <= {r_latch_sync[1:0], latch_i};
            r_data_sync  <= {r_data_sync[0], data_i};
        end
    end

`ifdef SHIFT_RX_TIMEOUT_EN
    localparam int C_IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [C_IDLE_W-1:0] r_idle;

    // Fires on the cycle the counter would reach TIMEOUT_CYCLES with no edge pending.
    assign w_timeout = !w_sclk_rise && !w_latch_rise && (r_cnt != '0) &&
                       (r_idle == C_IDLE_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_idle <= '0;
        end else if (w_sclk_rise || w_latch_rise || w_timeout || (r_cnt == '0)) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    // Shift is applied before the latch so a coincident final bit is counted.
    always_comb begin
        w_shreg_next = r_shreg;
        w_cnt_next   = r_cnt;
        w_valid_next = 1'b0;
        w_err_next   = 1'b0;
        w_load       = 1'b0;
        if (w_sclk_rise) begin
            w_shreg_next = {r_shreg[WIDTH-2:0], r_data_sync[1]};
            if (r_cnt != C_OVER) begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end
        if (w_latch_rise) begin
            if (w_cnt_next == C_FULL) begin
                w_load       = 1'b1;
                w_valid_next = 1'b1;
            end else begin
                w_err_next   = 1'b1;
            end
            w_cnt_next = '0;
        end else if (w_timeout) begin
            w_cnt_next = '0;
            w_err_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_shreg <= w_shreg_next;
            r_cnt   <= w_cnt_next;
            r_valid <= w_valid_next;
            r_err   <= w_err_next;
            r_busy  <= (w_cnt_next != '0);
            if (w_load) begin
                r_data <= w_shreg_next;
            end
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign err_o   = r_err;
    assign busy_o  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_shift_rx.sv
//============================================================================
// Module      : tb_shift_rx
// Description : Self-checking bench for shift_rx (table vectors + corner cases).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_shift_rx;

    localparam int WIDTH = 48;
    localparam int TOUT  = 16;

    logic             clk;
    logic             rst_i;
    logic             sclk_i;
    logic             data_i;
    logic             latch_i;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic             err_o;
    logic             busy_o;

    shift_rx #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .sclk_i  (sclk_i),
        .data_i  (data_i),
        .latch_i (latch_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .err_o   (err_o),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_valid_cyc = 0;
    int n_err_cyc   = 0;

    // Count high cycles of each pulse output, sampled away from the active edge.
    always @(negedge clk) begin
        if (valid_o === 1'b1) n_valid_cyc++;
        if (err_o === 1'b1)   n_err_cyc++;
    end

    typedef struct {
        logic [63:0] word;
        int          nbits;
        logic        exp_valid;
        logic        exp_err;
        logic [47:0] exp_data;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        data_i = b;
        cyc(2);
        sclk_i = 1'b1;
        cyc(4);
        sclk_i = 1'b0;
        cyc(2);
    endtask

    task automatic send_bits(input logic [63:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    // Raises latch, checks the pulse lands exactly 3 edges later and lasts 1 cycle.
    task automatic do_latch(input string name, input logic ev, input logic ee);
        logic v0, e0, v1, e1;
        latch_i = 1'b1;
        cyc(2);
        chk({name, " early valid"}, {63'd0, valid_o}, 64'd0);
        cyc(1);
        v0 = valid_o; e0 = err_o;
        cyc(1);
        v1 = valid_o; e1 = err_o;
        chk({name, " valid"}, {63'd0, v0}, {63'd0, ev});
        chk({name, " err"},   {63'd0, e0}, {63'd0, ee});
        chk({name, " pulse width"}, {62'd0, v1, e1}, 64'd0);
        cyc(2);
        latch_i = 1'b0;
        cyc(4);
    endtask

    vec_t vecs[7];
    int   cv, ce;

    initial begin
        vecs[0] = '{64'h0000_A5A5_0123_FEDC, 48, 1'b1, 1'b0, 48'hA5A5_0123_FEDC};
        vecs[1] = '{64'h0000_1234_5678_9ABC, 47, 1'b0, 1'b1, 48'hA5A5_0123_FEDC};
        vecs[2] = '{64'h0000_0000_0000_0001, 48, 1'b1, 1'b0, 48'h0000_0000_0001};
        vecs[3] = '{64'h0003_FFFF_0000_FFFF, 50, 1'b0, 1'b1, 48'h0000_0000_0001};
        vecs[4] = '{64'h0000_DEAD_BEEF_CAFE, 48, 1'b1, 1'b0, 48'hDEAD_BEEF_CAFE};
        vecs[5] = '{64'h0000_0000_0000_0000,  0, 1'b0, 1'b1, 48'hDEAD_BEEF_CAFE};
        vecs[6] = '{64'h0000_8000_0000_0000, 48, 1'b1, 1'b0, 48'h8000_0000_0000};

        rst_i = 1'b1; sclk_i = 1'b0; data_i = 1'b0; latch_i = 1'b0;
        cyc(3);
        chk("reset data",  {16'd0, data_o}, 64'd0);
        chk("reset flags", {61'd0, valid_o, err_o, busy_o}, 64'd0);
        rst_i = 1'b0;
        cyc(3);

        foreach (vecs[k]) begin
            cv = n_valid_cyc; ce = n_err_cyc;
            send_bits(vecs[k].word, vecs[k].nbits);
            chk($sformatf("v%0d busy mid", k), {63'd0, busy_o}, {63'd0, vecs[k].nbits != 0});
            do_latch($sformatf("v%0d", k), vecs[k].exp_valid, vecs[k].exp_err);
            chk($sformatf("v%0d data", k), {16'd0, data_o}, {16'd0, vecs[k].exp_data});
            chk($sformatf("v%0d busy after", k), {63'd0, busy_o}, 64'd0);
            chk($sformatf("v%0d pulse counts", k), {32'(n_valid_cyc - cv), 32'(n_err_cyc - ce)},
                {32'(vecs[k].exp_valid), 32'(vecs[k].exp_err)});
        end

        // Final bit and latch rising in the same cycle.
        cv = n_valid_cyc;
        send_bits(64'h0000_1234_5678_9ABD >> 1, 47);
        data_i = 1'b1;
        cyc(2);
        sclk_i = 1'b1;
        do_latch("coincident", 1'b1, 1'b0);
        sclk_i = 1'b0;
        chk("coincident data", {16'd0, data_o}, 64'h0000_1234_5678_9ABD);
        chk("coincident valid count", 64'(n_valid_cyc - cv), 64'd1);

        // Asynchronous reset in the middle of a frame.
        ce = n_err_cyc; cv = n_valid_cyc;
        send_bits(64'hFFFFF, 20);
        @(posedge clk); #3;
        rst_i = 1'b1;
        #1;
        chk("midreset data", {16'd0, data_o}, 64'd0);
        chk("midreset flags", {61'd0, valid_o, err_o, busy_o}, 64'd0);
        cyc(2);
        rst_i = 1'b0;
        cyc(3);
        chk("midreset no pulse", {32'(n_valid_cyc - cv), 32'(n_err_cyc - ce)}, 64'd0);
        send_bits(64'h0000_FFFF_FFFF_FFFF, 48);
        do_latch("after reset", 1'b1, 1'b0);
        chk("after reset data", {16'd0, data_o}, 64'h0000_FFFF_FFFF_FFFF);

        // Partial frame left idle.
        ce = n_err_cyc;
        send_bits(64'h2AA, 10);
        cyc(40);
`ifdef SHIFT_RX_TIMEOUT_EN
        chk("idle err count", 64'(n_err_cyc - ce), 64'd1);
        chk("idle busy", {63'd0, busy_o}, 64'd0);
`else
        chk("idle err count", 64'(n_err_cyc - ce), 64'd0);
        chk("idle busy", {63'd0, busy_o}, 64'd1);
`endif
        do_latch("idle latch", 1'b0, 1'b1);
        send_bits(64'h0000_0F0F_1234_C3C3, 48);
        do_latch("post idle", 1'b1, 1'b0);
        chk("post idle data", {16'd0, data_o}, 64'h0000_0F0F_1234_C3C3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
